// File: rtl/png_chunk_chk_pkg.sv
// Shared constants for the PNG chunk CRC path: the CRC-32 parameters, the
// checker FSM state type and the common chunk type codes.
package png_pkg;

  localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

  localparam logic [31:0] CHUNK_IHDR = 32'h4948_4452;
  localparam logic [31:0] CHUNK_IDAT = 32'h4944_4154;
  localparam logic [31:0] CHUNK_IEND = 32'h4945_4E44;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_TYPE,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/png_chunk_chk_if.sv
// Chunk stream bus.
//   start_i/val_i/dat_i/lst_i : chunk words from the stream reader
//   typ_o/len_o               : latched chunk header fields
//   val_o/dat_o/nbyt_o/lst_o  : forwarded data words
//   done_o/err_o              : end-of-chunk check result
// slave = checker side, master = stream/sink side.
interface png_chunk_if #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned LEN_WD  = 32
);
  logic               start_i;
  logic               val_i;
  logic [DATA_WD-1:0] dat_i;
  logic               lst_i;
  logic [31:0]        typ_o;
  logic [LEN_WD-1:0]  len_o;
  logic               val_o;
  logic [DATA_WD-1:0] dat_o;
  logic [2:0]         nbyt_o;
  logic               lst_o;
  logic               done_o;
  logic               err_o;

  modport slave (
    input  start_i, val_i, dat_i, lst_i,
    output typ_o, len_o, val_o, dat_o, nbyt_o, lst_o, done_o, err_o
  );

  modport master (
    output start_i, val_i, dat_i, lst_i,
    input  typ_o, len_o, val_o, dat_o, nbyt_o, lst_o, done_o, err_o
  );
endinterface

// File: rtl/png_chunk_chk_crc32_upd.sv
// Combinational CRC-32 (reflected) update over the nbyt leading bytes of a
// big-endian word; dat[31:24] is folded first, each byte LSB-first.
//   crc_in  : running CRC register
//   dat     : input word
//   nbyt    : number of leading bytes to fold (0..4)
//   crc_out : updated CRC register
module crc32_upd
  import png_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] dat,
  input  logic [2:0]  nbyt,
  output logic [31:0] crc_out
);

  logic [31:0] acc;

  always_comb begin
    acc = crc_in;
    for (int unsigned b = 0; b < 4; b++) begin
      if (b < 32'(nbyt)) begin
        acc = acc ^ {24'h0, dat[31-8*b -: 8]};
        for (int unsigned k = 0; k < 8; k++) begin
          acc = acc[0] ? ((acc >> 1) ^ CRC32_POLY) : (acc >> 1);
        end
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/png_chunk_chk.sv
// PNG chunk checker: strips length/type/CRC framing, forwards data words,
// and checks the received CRC-32 over type and data bytes.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : png_chunk_if.slave (input chunk stream, data out, result)
module png_chunk_chk #(
  parameter int unsigned DATA_WD  = 32,
  parameter int unsigned LEN_WD   = 32,
  parameter logic [31:0] CRC_INIT = png_pkg::CRC_INIT
) (
  input logic        clk,
  input logic        rstn,
  png_chunk_if.slave bus
);
  import png_pkg::*;

  state_e             state_q, state_d;
  logic [31:0]        crc_q, crc_d, crc_nxt;
  logic [LEN_WD-1:0]  rem_q, rem_d;
  logic [LEN_WD-1:0]  len_q, len_d;
  logic [31:0]        typ_q, typ_d;
  logic               err_q, err_d;
  logic               val_q, val_d;
  logic               lst_q, lst_d;
  logic [DATA_WD-1:0] dat_q, dat_d;
  logic [2:0]         nbyt_q, nbyt_d;

  logic [2:0]         nb;
  logic [2:0]         upd_nbyt;
  logic [DATA_WD-1:0] mask;
  logic [LEN_WD-1:0]  len_w;

  // Bytes carried by the current data word, and the mask keeping only them.
  always_comb begin
    nb = (rem_q >= LEN_WD'(4)) ? 3'd4 : rem_q[2:0];
    mask = '1;
    for (int unsigned b = 0; b < 4; b++) begin
      if (b >= 32'(nb)) mask[DATA_WD-1-8*b -: 8] = 8'h00;
    end
    upd_nbyt = (state_q == ST_TYPE) ? 3'd4 : nb;
    len_w    = LEN_WD'(bus.dat_i);
  end

  crc32_upd u_crc (
    .crc_in  (crc_q),
    .dat     (bus.dat_i[31:0]),
    .nbyt    (upd_nbyt),
    .crc_out (crc_nxt)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    rem_d   = rem_q;
    len_d   = len_q;
    typ_d   = typ_q;
    err_d   = err_q;
    val_d   = 1'b0;
    lst_d   = 1'b0;
    dat_d   = dat_q;
    nbyt_d  = nbyt_q;

    // start_i wins over everything, including the DONE cycle.
    if (bus.start_i) begin
      state_d = ST_LEN;
      crc_d   = CRC_INIT;
      rem_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_LEN: begin
          if (bus.val_i) begin
            if (bus.lst_i) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              len_d = len_w;
              rem_d = len_w;
              if (len_w[LEN_WD-1]) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end else begin
                state_d = ST_TYPE;
              end
            end
          end
        end
        ST_TYPE: begin
          if (bus.val_i) begin
            if (bus.lst_i) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              typ_d   = bus.dat_i[31:0];
              crc_d   = crc_nxt;
              state_d = (len_q == '0) ? ST_CRC : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bus.val_i) begin
            if (bus.lst_i) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              crc_d  = crc_nxt;
              rem_d  = rem_q - LEN_WD'(nb);
              val_d  = 1'b1;
              dat_d  = bus.dat_i & mask;
              nbyt_d = nb;
              if (rem_q <= LEN_WD'(4)) begin
                lst_d   = 1'b1;
                state_d = ST_CRC;
              end
            end
          end
        end
        ST_CRC: begin
          if (bus.val_i) begin
            err_d   = (bus.dat_i[31:0] != (crc_q ^ CRC_XOROUT)) || !bus.lst_i;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      crc_q   <= CRC_INIT;
      rem_q   <= '0;
      len_q   <= '0;
      typ_q   <= '0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
      lst_q   <= 1'b0;
      dat_q   <= '0;
      nbyt_q  <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      typ_q   <= typ_d;
      err_q   <= err_d;
      val_q   <= val_d;
      lst_q   <= lst_d;
      dat_q   <= dat_d;
      nbyt_q  <= nbyt_d;
    end
  end

  assign bus.typ_o  = typ_q;
  assign bus.len_o  = len_q;
  assign bus.val_o  = val_q;
  assign bus.dat_o  = dat_q;
  assign bus.nbyt_o = nbyt_q;
  assign bus.lst_o  = lst_q;
  assign bus.done_o = (state_q == ST_DONE);
  assign bus.err_o  = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_png_chunk_chk.sv
module tb_png_chunk_chk;

  localparam logic [31:0] POLY = 32'hEDB8_8320;
  localparam logic [31:0] IEND = 32'h4945_4E44;
  localparam logic [31:0] IDAT = 32'h4944_4154;
  localparam logic [31:0] IHDR = 32'h4948_4452;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  png_chunk_if #(.DATA_WD(32), .LEN_WD(32)) bus ();

  png_chunk_chk #(.DATA_WD(32), .LEN_WD(32), .CRC_INIT(32'hFFFF_FFFF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  bit          stall_en = 0;
  int unsigned exp_dcyc;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] obs_dat[$];
  logic [2:0]  obs_nb[$];
  logic        obs_lst[$];
  logic        obs_err[$];
  int unsigned obs_dcyc[$];
  logic [31:0] exp_dat[$];
  logic [2:0]  exp_nb[$];
  logic        exp_lst[$];

  always @(negedge clk) begin
    if (bus.val_o) begin
      obs_dat.push_back(bus.dat_o);
      obs_nb.push_back(bus.nbyt_o);
      obs_lst.push_back(bus.lst_o);
    end
    if (bus.done_o) begin
      obs_err.push_back(bus.err_o);
      obs_dcyc.push_back(cyc);
    end
  end

  // Reference CRC-32 over the type bytes then the data bytes, bit-serial.
  function automatic logic [31:0] ref_crc(input logic [31:0] typ, input logic [7:0] d[$]);
    logic [7:0]  all[$];
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 3; i >= 0; i--) all.push_back(typ[8*i +: 8]);
    foreach (d[i]) all.push_back(d[i]);
    foreach (all[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ all[i][k]) c = (c >> 1) ^ POLY;
        else                  c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Expected forwarded words: bytes grouped by four, zero-padded.
  task automatic expect_words(input logic [7:0] d[$]);
    for (int w = 0; 4 * w < d.size(); w++) begin
      logic [31:0] word;
      int          n;
      n = d.size() - 4 * w;
      if (n > 4) n = 4;
      word = '0;
      for (int b = 0; b < n; b++) word[31-8*b -: 8] = d[4*w+b];
      exp_dat.push_back(word);
      exp_nb.push_back(3'(n));
      exp_lst.push_back(4 * w + n == d.size());
    end
  endtask

  task automatic clear_q();
    obs_dat.delete(); obs_nb.delete(); obs_lst.delete(); obs_err.delete(); obs_dcyc.delete();
    exp_dat.delete(); exp_nb.delete(); exp_lst.delete();
  endtask

  task automatic drive(input logic s, input logic v, input logic l, input logic [31:0] d);
    @(negedge clk);
    bus.start_i = s;
    bus.val_i   = v;
    bus.lst_i   = l;
    bus.dat_i   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    if (stall_en) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 32'($urandom));
    drive(1'b0, 1'b1, l, d);
  endtask

  task automatic send_chunk(input logic [31:0] typ, input logic [31:0] len, input logic [7:0] d[$],
                            input logic [31:0] crc, input bit garbage);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    send_word(len, 1'b0);
    send_word(typ, 1'b0);
    for (int w = 0; 4 * w < d.size(); w++) begin
      logic [31:0] word;
      for (int b = 0; b < 4; b++)
        word[31-8*b -: 8] = (4 * w + b < d.size()) ? d[4*w+b] : (garbage ? 8'($urandom) : 8'h00);
      send_word(word, 1'b0);
    end
    send_word(crc, 1'b1);
    exp_dcyc = cyc + 1;
  endtask

  task automatic wait_done(input int n);
    for (int t = 0; t < 40 && obs_err.size() < n; t++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      #1;
    end
    idle(3);
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({bus.val_o, bus.lst_o, bus.done_o, bus.err_o} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, expected 0000", {bus.val_o, bus.lst_o, bus.done_o, bus.err_o});
    end
    tests++;
    if ({bus.typ_o, bus.len_o, bus.dat_o, bus.nbyt_o} !== '0) begin
      fails++;
      $display("FAIL reset_fields: got typ %h len %h dat %h nbyt %0d, expected all 0",
               bus.typ_o, bus.len_o, bus.dat_o, bus.nbyt_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_iend(input logic [31:0] crc, input string name);
    logic [7:0] d[$];
    logic       exp_err;
    clear_q();
    exp_err = (crc !== ref_crc(IEND, d));
    send_chunk(IEND, 32'd0, d, crc, 1'b0);
    wait_done(1);
    tests++;
    if (obs_dat.size() != 0) begin
      fails++;
      $display("FAIL %s_noval: got %0d data words, expected 0", name, obs_dat.size());
    end
    tests++;
    if (bus.typ_o !== IEND || bus.len_o !== 32'd0) begin
      fails++;
      $display("FAIL %s_hdr: got typ %h len %h, expected typ %h len 0", name, bus.typ_o, bus.len_o, IEND);
    end
    tests++;
    if (obs_err.size() != 1 || obs_err[0] !== exp_err) begin
      fails++;
      $display("FAIL %s_done: got %0d done(s) err %b, expected 1 done err %b", name, obs_err.size(), obs_err[0], exp_err);
    end
    tests++;
    if (obs_dcyc.size() != 1 || obs_dcyc[0] != exp_dcyc) begin
      fails++;
      $display("FAIL %s_latency: got done at cycle %0d, expected %0d", name, obs_dcyc[0], exp_dcyc);
    end
  endtask

  task automatic test_partial(input bit stall, input string name);
    logic [7:0] d[$];
    logic       exp_err;
    clear_q();
    d = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    expect_words(d);
    exp_err  = (32'hCBF4_3926 !== ref_crc(32'h3132_3334, d));
    stall_en = stall;
    send_chunk(32'h3132_3334, 32'd5, d, 32'hCBF4_3926, 1'b0);
    stall_en = 0;
    wait_done(1);
    tests++;
    if (obs_dat.size() != exp_dat.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d words, expected %0d", name, obs_dat.size(), exp_dat.size());
    end else begin
      foreach (exp_dat[i]) begin
        tests++;
        if ({obs_dat[i], obs_nb[i], obs_lst[i]} !== {exp_dat[i], exp_nb[i], exp_lst[i]}) begin
          fails++;
          $display("FAIL %s_word%0d: got %h/%0d/%b, expected %h/%0d/%b", name, i,
                   obs_dat[i], obs_nb[i], obs_lst[i], exp_dat[i], exp_nb[i], exp_lst[i]);
        end
      end
    end
    tests++;
    if (obs_err.size() != 1 || obs_err[0] !== exp_err || obs_dcyc[0] != exp_dcyc) begin
      fails++;
      $display("FAIL %s_done: got %0d done(s) err %b at %0d, expected 1 err %b at %0d", name,
               obs_err.size(), obs_err[0], obs_dcyc[0], exp_err, exp_dcyc);
    end
  endtask

  task automatic test_framing();
    clear_q();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    send_word(32'd4, 1'b0);
    send_word(IDAT, 1'b1);
    exp_dcyc = cyc + 1;
    wait_done(1);
    tests++;
    if (obs_err.size() != 1 || obs_err[0] !== 1'b1 || obs_dcyc[0] != exp_dcyc || obs_dat.size() != 0) begin
      fails++;
      $display("FAIL framing_lst_type: got %0d done(s) err %b at %0d, %0d words; expected 1 err 1 at %0d, 0 words",
               obs_err.size(), obs_err[0], obs_dcyc[0], obs_dat.size(), exp_dcyc);
    end
    clear_q();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    send_word(32'h8000_0000, 1'b0);
    exp_dcyc = cyc + 1;
    send_word(IDAT, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    wait_done(1);
    tests++;
    if (obs_err.size() != 1 || obs_err[0] !== 1'b1 || obs_dcyc[0] != exp_dcyc || obs_dat.size() != 0) begin
      fails++;
      $display("FAIL framing_len: got %0d done(s) err %b at %0d, %0d words; expected 1 err 1 at %0d, 0 words",
               obs_err.size(), obs_err[0], obs_dcyc[0], obs_dat.size(), exp_dcyc);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d[$];
    clear_q();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    send_word(32'd8, 1'b0);
    send_word(IDAT, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_chunk(IEND, 32'd0, d, ref_crc(IEND, d), 1'b0);
    wait_done(1);
    tests++;
    if (obs_err.size() != 1 || obs_err[0] !== 1'b0 || bus.typ_o !== IEND) begin
      fails++;
      $display("FAIL abort: got %0d done(s) err %b typ %h, expected 1 done err 0 typ %h",
               obs_err.size(), obs_err[0], bus.typ_o, IEND);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  d[$];
    logic [7:0]  e[$];
    int unsigned a_dcyc;
    clear_q();
    d = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    expect_words(d);
    send_chunk(32'h3132_3334, 32'd5, d, ref_crc(32'h3132_3334, d), 1'b1);
    a_dcyc = exp_dcyc;
    send_chunk(IEND, 32'd0, e, ref_crc(IEND, e), 1'b0);
    wait_done(2);
    tests++;
    if (obs_err.size() != 2 || obs_err[0] !== 1'b0 || obs_err[1] !== 1'b0 ||
        obs_dcyc[0] != a_dcyc || obs_dcyc[1] != exp_dcyc) begin
      fails++;
      $display("FAIL b2b_done: got %0d done(s) errs %b%b at %0d/%0d, expected 2 errs 00 at %0d/%0d",
               obs_err.size(), obs_err[0], obs_err[1], obs_dcyc[0], obs_dcyc[1], a_dcyc, exp_dcyc);
    end
    tests++;
    if (obs_dat.size() != exp_dat.size() || obs_dat[1] !== exp_dat[1] || obs_lst[1] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_data: got %0d words last %h, expected %0d words last %h",
               obs_dat.size(), obs_dat[1], exp_dat.size(), exp_dat[1]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0]  d[$];
      logic [31:0] typ, crc;
      logic [31:0] len;
      logic        exp_err;
      clear_q();
      len = 32'($urandom_range(0, 13));
      for (int i = 0; i < int'(len); i++) d.push_back(8'($urandom));
      case ($urandom_range(0, 2))
        0:       typ = IHDR;
        1:       typ = IDAT;
        default: typ = 32'($urandom);
      endcase
      crc = ref_crc(typ, d);
      if ($urandom_range(0, 3) == 0) crc = crc ^ (32'd1 << $urandom_range(0, 31));
      exp_err = (crc !== ref_crc(typ, d));
      expect_words(d);
      stall_en = ($urandom_range(0, 1) == 1);
      send_chunk(typ, len, d, crc, 1'b1);
      stall_en = 0;
      wait_done(1);
      tests++;
      if (obs_dat.size() != exp_dat.size()) begin
        fails++;
        $display("FAIL rand%0d_count: got %0d words, expected %0d", n, obs_dat.size(), exp_dat.size());
      end else begin
        foreach (exp_dat[i]) begin
          tests++;
          if ({obs_dat[i], obs_nb[i], obs_lst[i]} !== {exp_dat[i], exp_nb[i], exp_lst[i]}) begin
            fails++;
            $display("FAIL rand%0d_word%0d: got %h/%0d/%b, expected %h/%0d/%b", n, i,
                     obs_dat[i], obs_nb[i], obs_lst[i], exp_dat[i], exp_nb[i], exp_lst[i]);
          end
        end
      end
      tests++;
      if (obs_err.size() != 1 || obs_err[0] !== exp_err || obs_dcyc[0] != exp_dcyc ||
          bus.typ_o !== typ || bus.len_o !== len) begin
        fails++;
        $display("FAIL rand%0d_done: got %0d done(s) err %b at %0d typ %h len %0d, expected err %b at %0d typ %h len %0d",
                 n, obs_err.size(), obs_err[0], obs_dcyc[0], bus.typ_o, bus.len_o, exp_err, exp_dcyc, typ, len);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    send_word(32'd8, 1'b0);
    send_word(IDAT, 1'b0);
    send_word(32'h0102_0304, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    clear_q();
    rstn = 1'b0;
    #1;
    tests++;
    if ({bus.val_o, bus.lst_o, bus.done_o, bus.err_o} !== 4'b0 ||
        {bus.typ_o, bus.len_o, bus.dat_o, bus.nbyt_o} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got typ %h len %h dat %h nbyt %0d flags %b, expected all 0",
               bus.typ_o, bus.len_o, bus.dat_o, bus.nbyt_o, {bus.val_o, bus.lst_o, bus.done_o, bus.err_o});
    end
    idle(2);
    rstn = 1'b1;
    send_word(32'h0506_0708, 1'b0);
    send_word(32'h1122_3344, 1'b1);
    idle(6);
    tests++;
    if (obs_err.size() != 0 || obs_dat.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_quiet: got %0d done(s) %0d words, expected 0 and 0", obs_err.size(), obs_dat.size());
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.val_i   = 1'b0;
    bus.lst_i   = 1'b0;
    bus.dat_i   = '0;
    test_reset();
    test_iend(32'hAE42_6082, "iend");
    test_partial(1'b0, "partial");
    test_iend(32'hAE42_6083, "bad_crc");
    test_framing();
    test_partial(1'b1, "stall");
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
